pattern_resp_misr_compactor: RTL and testbench

// Downstream consumer of a generated pattern-merge netlist. Captures the 12-bit

---
 rtl/pattern_resp_misr_compactor_pkg.sv | 29 ++
 rtl/pattern_resp_misr_compactor_misr_core.sv | 60 ++++++
 rtl/pattern_resp_misr_compactor.sv | 129 ++++++++++++
 tb/tb_pattern_resp_misr_compactor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_resp_misr_compactor_pkg.sv
// Shared types, default MISR constants and a reference MISR step for the
// pattern-response compactor.
package pattern_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          MISR_SIG_W_DEF = 16;
  localparam int          MISR_IN_W_DEF  = 12;
  localparam logic [15:0] MISR_POLY_DEF  = 16'h1021;  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] MISR_SEED_DEF  = 16'hFFFF;

  // One MISR step at the default widths: shift left, fold the tap polynomial
  // in when the MSB falls out, then xor the zero-extended response.
  function automatic logic [15:0] misr_next(input logic [15:0] misr,
                                            input logic [11:0] resp,
                                            input logic [15:0] poly);
    logic [15:0] shifted;
    shifted = {misr[14:0], 1'b0};
    if (misr[15]) begin
      shifted = shifted ^ poly;
    end
    return shifted ^ {4'h0, resp};
  endfunction

endpackage

// File: rtl/pattern_resp_misr_compactor_misr_core.sv
// MISR register: reloads SEED on reset or load_seed_i, absorbs one response
// vector per cycle when en_i is high. Exposes the next value so the caller
// can register a comparison against it.
module misr_core
  import pattern_cmp_pkg::*;
#(
  parameter int               SIG_W = MISR_SIG_W_DEF,
  parameter int               IN_W  = MISR_IN_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY_DEF,
  parameter logic [SIG_W-1:0] SEED  = MISR_SEED_DEF
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load_seed_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  resp_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [SIG_W-1:0] nxt_o
);

  // The response is zero-extended into the signature; it cannot be wider.
  generate
    if (IN_W > SIG_W) begin : g_width_check
      $error("misr_core: IN_W must not exceed SIG_W");
    end
  endgenerate

  logic [SIG_W-1:0] misr_q;
  logic [SIG_W-1:0] misr_d;
  logic [SIG_W-1:0] resp_ext;

  assign resp_ext = SIG_W'(resp_i);

  // Next MISR value in SIG_W-bit modular arithmetic.
  always_comb begin
    nxt_o = {misr_q[SIG_W-2:0], 1'b0} ^ (misr_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
  end

  // Seed reload has priority over absorbing a sample.
  always_comb begin
    misr_d = misr_q;
    if (load_seed_i) begin
      misr_d = SEED;
    end else if (en_i) begin
      misr_d = nxt_o;
    end
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (srst) begin
      misr_q <= SEED;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign sig_o = misr_q;

endmodule

// File: rtl/pattern_resp_misr_compactor.sv
// Compacts a programmed number of netlist response vectors into a MISR
// signature, then offers it with a valid/ready handshake and a pass flag
// against the golden value latched at start.
module pattern_resp_misr_compactor
  import pattern_cmp_pkg::*;
#(
  parameter int               IN_W  = MISR_IN_W_DEF,
  parameter int               SIG_W = MISR_SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY_DEF,
  parameter logic [SIG_W-1:0] SEED  = MISR_SEED_DEF,
  parameter int               CNT_W = 16
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic [IN_W-1:0]  resp_in,
  input  logic             resp_vld,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [SIG_W-1:0] sig_out,
  output logic             sig_vld,
  input  logic             sig_rdy,
  output logic             pass
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             load_seed;
  logic             misr_en;
  logic [SIG_W-1:0] misr_sig;
  logic [SIG_W-1:0] misr_nxt;

  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  misr_core #(
    .SIG_W (SIG_W),
    .IN_W  (IN_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk         (blif_clk_net),
    .srst        (blif_reset_net),
    .load_seed_i (load_seed),
    .en_i        (misr_en),
    .resp_i      (resp_in),
    .sig_o       (misr_sig),
    .nxt_o       (misr_nxt)
  );

  // Run control: start/latch in IDLE, absorb samples in RUN, hold the
  // signature in DONE until the consumer takes it. The pass flag is computed
  // from the value the MISR is about to hold, so it is ready with sig_vld.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    exp_d     = exp_q;
    pass_d    = pass_q;
    load_seed = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_seed = 1'b1;
          cnt_d     = '0;
          target_d  = num_samples;
          exp_d     = exp_sig;
          if (num_samples == '0) begin
            state_d = DONE;
            pass_d  = (SEED == exp_sig);
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (resp_vld) begin
          misr_en = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == target_q) begin
            state_d = DONE;
            pass_d  = (misr_nxt == exp_q);
          end
        end
      end
      DONE: begin
        if (sig_rdy) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State, counter, latched run parameters and pass flag.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      exp_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      exp_q    <= exp_d;
      pass_q   <= pass_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign sig_vld    = (state_q == DONE);
  assign sample_cnt = cnt_q;
  assign sig_out    = misr_sig;
  assign pass       = pass_q;

endmodule

// File: tb/tb_pattern_resp_misr_compactor.sv
// Directed bench for pattern_resp_misr_compactor: stimulus pushes expected
// signatures into a queue, a monitor pops and compares on each handshake.
module tb_pattern_resp_misr_compactor;

  logic        clk;
  logic        srst;
  logic        start;
  logic [15:0] num_samples;
  logic [15:0] exp_sig;
  logic [11:0] resp_in;
  logic        resp_vld;
  logic        busy;
  logic [15:0] sample_cnt;
  logic [15:0] sig_out;
  logic        sig_vld;
  logic        sig_rdy;
  logic        pass;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  pattern_resp_misr_compactor dut (
    .blif_clk_net   (clk),
    .blif_reset_net (srst),
    .start          (start),
    .num_samples    (num_samples),
    .exp_sig        (exp_sig),
    .resp_in        (resp_in),
    .resp_vld       (resp_vld),
    .busy           (busy),
    .sample_cnt     (sample_cnt),
    .sig_out        (sig_out),
    .sig_vld        (sig_vld),
    .sig_rdy        (sig_rdy),
    .pass           (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MISR step written from the polynomial definition.
  function automatic logic [15:0] ref_step(input logic [15:0] m, input logic [11:0] r);
    logic [15:0] s;
    s = m << 1;
    if (m[15]) s = s ^ 16'h1021;
    return s ^ {4'h0, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [15:0] e);
    start       = 1'b1;
    num_samples = n;
    exp_sig     = e;
    tick();
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] s, input logic p, input logic [15:0] c);
    exp_t e;
    e.sig  = s;
    e.pass = p;
    e.cnt  = c;
    sb_q.push_back(e);
  endtask

  // Monitor: every accepted signature is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!srst && sig_vld && sig_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sig: got sig=%h with empty scoreboard", sig_out);
        end else begin
          e = sb_q.pop_front();
          $display("txn sig=%h pass=%0b cnt=%0d (exp sig=%h pass=%0b cnt=%0d)",
                   sig_out, pass, sample_cnt, e.sig, e.pass, e.cnt);
          chk("txn_sig", 32'(sig_out), 32'(e.sig));
          chk("txn_pass", 32'(pass), 32'(e.pass));
          chk("txn_cnt", 32'(sample_cnt), 32'(e.cnt));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] vals4 [4];
    logic [15:0] m;

    srst        = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    exp_sig     = '0;
    resp_in     = '0;
    resp_vld    = 1'b0;
    sig_rdy     = 1'b1;
    tick();
    tick();
    srst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(sig_vld), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_sig", 32'(sig_out), 32'hFFFF);
    chk("rst_pass", 32'(pass), 32'd0);

    // 1: reset mid-RUN after 3 samples
    do_start(16'd10, 16'h0000);
    resp_vld = 1'b1;
    resp_in  = 12'h5A5;
    repeat (3) tick();
    resp_vld = 1'b0;
    chk("mid_cnt", 32'(sample_cnt), 32'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_vld", 32'(sig_vld), 32'd0);
    chk("mrst_cnt", 32'(sample_cnt), 32'd0);
    chk("mrst_sig", 32'(sig_out), 32'hFFFF);
    tick();

    // 2: single zero sample, matching and mismatching golden values
    push_exp(16'hEFDF, 1'b1, 16'd1);
    do_start(16'd1, 16'hEFDF);
    chk("one_vld_early", 32'(sig_vld), 32'd0);
    resp_in  = 12'h000;
    resp_vld = 1'b1;
    tick();
    resp_vld = 1'b0;
    chk("one_vld", 32'(sig_vld), 32'd1);
    chk("one_sig", 32'(sig_out), 32'hEFDF);
    tick();
    chk("one_idle", 32'(sig_vld), 32'd0);

    push_exp(16'hEFDF, 1'b0, 16'd1);
    do_start(16'd1, 16'hEFDE);
    resp_in  = 12'h000;
    resp_vld = 1'b1;
    tick();
    resp_vld = 1'b0;
    chk("one_fail_pass", 32'(pass), 32'd0);
    tick();

    push_exp(16'hEEFC, 1'b1, 16'd1);
    do_start(16'd1, 16'hEEFC);
    resp_in  = 12'h123;
    resp_vld = 1'b1;
    tick();
    resp_vld = 1'b0;
    tick();

    // 3: zero-length run
    push_exp(16'hFFFF, 1'b1, 16'd0);
    do_start(16'd0, 16'hFFFF);
    chk("zero_vld", 32'(sig_vld), 32'd1);
    chk("zero_sig", 32'(sig_out), 32'hFFFF);
    chk("zero_cnt", 32'(sample_cnt), 32'd0);
    tick();

    // 4: four samples with resp_vld toggling
    vals4[0] = 12'h0A5;
    vals4[1] = 12'h5A0;
    vals4[2] = 12'hFFF;
    vals4[3] = 12'h001;
    m = 16'hFFFF;
    for (int k = 0; k < 4; k++) m = ref_step(m, vals4[k]);
    push_exp(m, 1'b1, 16'd4);
    do_start(16'd4, m);
    for (int i = 0; i < 7; i++) begin
      resp_vld = (i % 2 == 0);
      resp_in  = (i % 2 == 0) ? vals4[i/2] : 12'hBAD;
      tick();
      chk($sformatf("tog_cnt%0d", i), 32'(sample_cnt), 32'(i / 2 + 1));
      chk($sformatf("tog_vld%0d", i), 32'(sig_vld), (i == 6) ? 32'd1 : 32'd0);
    end
    resp_vld = 1'b0;
    tick();

    // 5: DONE held with sig_rdy low while resp_vld and start toggle
    m = ref_step(ref_step(16'hFFFF, 12'h3C3), 12'h00F);
    push_exp(m, 1'b0, 16'd2);
    sig_rdy = 1'b0;
    do_start(16'd2, 16'h1234);
    resp_vld = 1'b1;
    resp_in  = 12'h3C3;
    tick();
    resp_in = 12'h00F;
    tick();
    for (int c = 0; c < 5; c++) begin
      resp_vld    = 1'b1;
      resp_in     = 12'h777 + 12'(c);
      start       = (c % 2 == 0);
      num_samples = 16'd0;
      tick();
      chk($sformatf("hold_sig%0d", c), 32'(sig_out), 32'(m));
      chk($sformatf("hold_vld%0d", c), 32'(sig_vld), 32'd1);
      chk($sformatf("hold_cnt%0d", c), 32'(sample_cnt), 32'd2);
    end
    start    = 1'b0;
    resp_vld = 1'b0;
    sig_rdy  = 1'b1;
    tick();
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_vld", 32'(sig_vld), 32'd0);

    // 6: back-to-back run right after the handshake; seed must be reloaded
    push_exp(16'hEFDF, 1'b1, 16'd1);
    do_start(16'd1, 16'hEFDF);
    resp_in  = 12'h000;
    resp_vld = 1'b1;
    tick();
    resp_vld = 1'b0;
    chk("b2b_sig", 32'(sig_out), 32'hEFDF);
    tick();
    tick();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
